// File: rtl/invsqrt_result_fifo_if.sv
// Stream bundle between the inverse-sqrt pipeline, its result FIFO and the consumer.
// The slave modport is the FIFO; the master modport is the pipeline/consumer side.
interface invsqrt_result_fifo_if #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic [31:0]       in_data;
    logic              stall;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic [LW-1:0]     level;
    logic              overflow;
    logic [CNT_W-1:0]  res_cnt;

    modport slave (
        input  in_valid, in_data, out_ready,
        output stall, out_valid, out_data, level, overflow, res_cnt
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  stall, out_valid, out_data, level, overflow, res_cnt
    );
endinterface

// File: rtl/invsqrt_result_fifo.sv
// Show-ahead result FIFO behind the inverse-sqrt pipeline with early stall request.
// Define INVSQRT_FIFO_STATS_EN to enable the delivered-result counter on res_cnt.
module invsqrt_result_fifo #(
    parameter int DEPTH = 16,
    parameter int SLACK = 6,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    invsqrt_result_fifo_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [LW-1:0] THRESH_L = LW'(DEPTH - SLACK);

    logic [31:0]    r_mem [DEPTH];
    logic [AW:0]    r_wr_ptr;
    logic [AW:0]    r_rd_ptr;
    logic [LW-1:0]  r_level;
    logic           r_stall;
    logic           r_overflow;
    logic [31:0]    r_out_data;

    logic           w_push;
    logic           w_pop;
    logic [LW-1:0]  w_next_level;
    logic [AW:0]    w_next_rd;
    logic [31:0]    w_next_head;

    always_comb begin
        w_pop        = (r_level != '0) & bus.out_ready;
        // At full, a simultaneous pop frees the slot that this push fills.
        w_push       = bus.in_valid & ((r_level != DEPTH_L) | w_pop);
        w_next_level = r_level + LW'(w_push) - LW'(w_pop);
        w_next_rd    = r_rd_ptr + LW'(w_pop);
        // If the new head is the entry being written this edge, take it from the input.
        if (w_push && (r_wr_ptr == w_next_rd)) begin
            w_next_head = bus.in_data;
        end else begin
            w_next_head = r_mem[w_next_rd[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_stall    <= 1'b0;
            r_overflow <= 1'b0;
            r_out_data <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr   <= w_next_rd;
            r_level    <= w_next_level;
            r_stall    <= (w_next_level >= THRESH_L);
            r_overflow <= r_overflow | (bus.in_valid & ~w_push);
            if (w_next_level != '0) begin
                r_out_data <= w_next_head;
            end
        end
    end

`ifdef INVSQRT_FIFO_STATS_EN
    logic [CNT_W-1:0] r_res_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_cnt <= '0;
        end else if (w_pop) begin
            r_res_cnt <= r_res_cnt + 1'b1;
        end
    end

    assign bus.res_cnt = r_res_cnt;
`else
    assign bus.res_cnt = '0;
`endif

    assign bus.stall     = r_stall;
    assign bus.out_valid = (r_level != '0);
    assign bus.out_data  = r_out_data;
    assign bus.level     = r_level;
    assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_invsqrt_result_fifo.sv
// Randomised and directed bench for invsqrt_result_fifo against a queue-based model.
module tb_invsqrt_result_fifo;
    localparam int DEPTH = 16;
    localparam int SLACK = 6;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    invsqrt_result_fifo_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    invsqrt_result_fifo #(.DEPTH(DEPTH), .SLACK(SLACK), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: plain queue plus sticky flags.
    logic [31:0]      mq [$];
    logic [31:0]      m_data = '0;
    logic             m_ovf = 1'b0;
    logic             m_stall = 1'b0;
    logic [CNT_W-1:0] m_cnt = '0;
    bit               m_live = 1'b0;
    bit               m_pop, m_push;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_data  = '0;
            m_ovf   = 1'b0;
            m_stall = 1'b0;
            m_cnt   = '0;
            m_live  = 1'b1;
        end else begin
            m_pop  = (mq.size() != 0) && bus.out_ready;
            m_push = bus.in_valid && ((mq.size() < DEPTH) || m_pop);
            if (m_pop) begin
                void'(mq.pop_front());
                m_cnt = m_cnt + 1'b1;
            end
            if (m_push) mq.push_back(bus.in_data);
            if (bus.in_valid && !m_push) m_ovf = 1'b1;
            m_stall = (mq.size() >= DEPTH - SLACK);
            if (mq.size() != 0) m_data = mq[0];
        end
    end

    function automatic logic [CNT_W-1:0] exp_cnt(input logic [CNT_W-1:0] c);
`ifdef INVSQRT_FIFO_STATS_EN
        return c;
`else
        return '0;
`endif
    endfunction

    always @(negedge clk) begin
        if (m_live) begin
            chk("out_valid", bus.out_valid, mq.size() != 0);
            chk("level", bus.level, mq.size());
            chk("stall", bus.stall, m_stall);
            chk("overflow", bus.overflow, m_ovf);
            chk("out_data", bus.out_data, m_data);
            chk("res_cnt", bus.res_cnt, exp_cnt(m_cnt));
        end
    end

    task automatic step(input logic v, input logic [31:0] d, input logic r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        logic v;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_out_data", bus.out_data, 0);

        // single push into empty FIFO
        step(1'b1, 32'h3F800000, 1'b0);
        chk("t1_valid", bus.out_valid, 1);
        chk("t1_data", bus.out_data, 32'h3F800000);
        chk("t1_level", bus.level, 1);

        // stall threshold at level 10
        for (int i = 1; i <= 9; i++) begin
            step(1'b1, 32'h1000 + i, 1'b0);
            if (i == 8) chk("t2_stall_lvl9", bus.stall, 0);
        end
        chk("t2_stall_lvl10", bus.stall, 1);
        chk("t2_level10", bus.level, 10);
        step(1'b0, 32'h0, 1'b1);
        chk("t2_stall_after_pop", bus.stall, 0);
        chk("t2_head", bus.out_data, 32'h1001);

        // overflow when full
        for (int i = 0; i < 7; i++) step(1'b1, 32'h2000 + i, 1'b0);
        chk("t3_level16", bus.level, 16);
        step(1'b1, 32'h40000000, 1'b0);
        chk("t3_level_hold", bus.level, 16);
        chk("t3_overflow", bus.overflow, 1);
        chk("t3_head", bus.out_data, 32'h1001);
        for (int i = 0; i < 16; i++) begin
            chk("t3_no_dropped", bus.out_data == 32'h40000000, 0);
            step(1'b0, 32'h0, 1'b1);
        end
        chk("t3_empty", bus.out_valid, 0);
        chk("t3_data_hold", bus.out_data, 32'h2006);
        chk("t3_ovf_sticky", bus.overflow, 1);

        // push and pop together at full
        for (int i = 0; i < 16; i++) step(1'b1, 32'h3000 + i, 1'b0);
        step(1'b1, 32'h5555AAAA, 1'b1);
        chk("t4_level", bus.level, 16);
        chk("t4_head", bus.out_data, 32'h3001);
        for (int i = 0; i < 15; i++) step(1'b0, 32'h0, 1'b1);
        chk("t4_new_at_head", bus.out_data, 32'h5555AAAA);
        chk("t4_level1", bus.level, 1);
        step(1'b0, 32'h0, 1'b1);
        chk("t4_level0", bus.level, 0);

        // reset mid-stream at level 5
        for (int i = 0; i < 5; i++) step(1'b1, 32'h6000 + i, 1'b0);
        chk("t6_level5", bus.level, 5);
        rst = 1'b1;
        step(1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        chk("t6_level", bus.level, 0);
        chk("t6_valid", bus.out_valid, 0);
        chk("t6_stall", bus.stall, 0);
        chk("t6_overflow", bus.overflow, 0);

        // 40-result stream, pipeline honouring stall, consumer toggling
        sent = 0;
        for (int c = 0; c < 400 && (sent < 40 || bus.out_valid); c++) begin
            v = (sent < 40) && !bus.stall;
            step(v, 32'hA000 + sent, (c % 2 == 0) || (sent >= 40));
            if (v) sent++;
        end
        chk("t5_done", (sent == 40) && !bus.out_valid, 1);
        chk("t5_data_last", bus.out_data, 32'hA000 + 39);
`ifdef INVSQRT_FIFO_STATS_EN
        chk("t5_res_cnt", bus.res_cnt, 40);
`else
        chk("t5_res_cnt", bus.res_cnt, 0);
`endif

        // random traffic: fill-biased, then drain-biased, occasional reset
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (c < 1500)
                step($urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 99) < 40);
            else
                step($urandom_range(0, 99) < 40, $urandom, $urandom_range(0, 99) < 70);
        end
        rst = 1'b0;
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
